// File: rtl/mux_arb_pkg.sv
// Shared types and the rotating priority pick for the 8-way bit-mux arbiter.
package mux_arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Scan descending so the last hit written is the one closest to ptr.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            p;
    logic [SEL_W-1:0] k;
    p = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      k = ptr + SEL_W'(i);
      if (req[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/muxer8.sv
// Plain 8:1 single-bit multiplexer shared by the arbitrated requesters.
module muxer8 (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       q
);
  assign q = in[sel];
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin burst arbiter driving a shared 8:1 bit mux with a valid/ready output.
// Optional MUX_ARB_STATS_EN adds grant_cnt (wrapping) and stall_cnt (saturating).
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  req,
  input  logic [7:0]  in,
  input  logic        q_ready,
  output logic        q,
  output logic        q_valid,
  output logic [2:0]  sel,
  output logic [7:0]  gnt,
  output logic        busy
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt,
  output logic [15:0] stall_cnt
`endif
);
  localparam int BEAT_W = 4;

  arb_state_t        state, state_n;
  logic [SEL_W-1:0]  sel_n, ptr, ptr_n;
  logic [N_REQ-1:0]  gnt_n;
  logic [BEAT_W-1:0] beat_cnt, beat_n;
  logic              xfer, last, rel;
  pick_t             pick;

  muxer8 u_mux (.in(in), .sel(sel), .q(q));

  assign busy    = (state == GRANT);
  assign q_valid = busy & req[sel];
  assign xfer    = q_valid & q_ready;
  assign last    = (beat_cnt == BEAT_W'(BURST_LEN-1));
  // Withdrawal releases without a transfer; otherwise only the final beat does.
  assign rel     = busy & (~req[sel] | (xfer & last));
  assign pick    = rr_pick(req, ptr);

  always_comb begin
    state_n = state;
    sel_n   = sel;
    gnt_n   = gnt;
    ptr_n   = ptr;
    beat_n  = beat_cnt;
    case (state)
      IDLE: begin
        if (pick.found) begin
          state_n = GRANT;
          sel_n   = pick.idx;
          gnt_n   = N_REQ'(1) << pick.idx;
          beat_n  = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_n = IDLE;
          ptr_n   = sel + SEL_W'(1);
          gnt_n   = '0;
        end else if (xfer) begin
          beat_n = beat_cnt + BEAT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      gnt      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      gnt      <= gnt_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_n;
    end
  end

`ifdef MUX_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (rel)
        grant_cnt <= grant_cnt + 16'd1;
      if (q_valid && !q_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: vector table plus multi-cycle burst sequences.
module tb_mux8_rr_arbiter;
  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req, din;
  logic       q_ready;
  logic       q, q_valid, busy;
  logic [2:0] sel;
  logic [7:0] gnt;
`ifdef MUX_ARB_STATS_EN
  logic [15:0] grant_cnt, stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  mux8_rr_arbiter #(.BURST_LEN(BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .in(din), .q_ready(q_ready),
    .q(q), .q_valid(q_valid), .sel(sel), .gnt(gnt), .busy(busy)
`ifdef MUX_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] din;
    logic       rdy;
    logic       e_q;
    logic       e_qv;
    logic [2:0] e_sel;
    logic [7:0] e_gnt;
    logic       e_busy;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; din = '0; q_ready = 1'b0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
    #1;
  endtask

  // Waits out the bubble, then counts beats of one grant; caller sits 1ns into a cycle.
  task automatic grant_run(input int idx, input int stall_n);
    int bub, n, beats;
    bub = 0;
    while (!busy && bub < 20) begin
      bub++;
      next_cyc();
      #1;
    end
    check("bubble_cycles", bub, 1);
    check("grant_sel", 32'(sel), idx);
    check("grant_gnt", 32'(gnt), 32'(1) << idx);
    n = 0; beats = 0;
    while (busy && n < 40) begin
      q_ready = (n < stall_n) ? 1'b0 : 1'b1;
      #1;
      if (n < stall_n) check("stall_q_valid", 32'(q_valid), 1);
      if (q_valid && q_ready) beats++;
      n++;
      next_cyc();
      #1;
    end
    check("burst_beats", beats, BURST);
    check("burst_cycles", n, BURST + stall_n);
  endtask

  initial begin
    vecs[0]  = '{8'h20, 8'h20, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[1]  = '{8'h20, 8'h20, 1'b1, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1};
    vecs[2]  = '{8'h20, 8'h20, 1'b1, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1};
    vecs[3]  = '{8'h20, 8'h20, 1'b1, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1};
    vecs[4]  = '{8'h20, 8'h20, 1'b1, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1};
    vecs[5]  = '{8'h20, 8'h20, 1'b1, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0};
    vecs[6]  = '{8'h20, 8'h20, 1'b1, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1};
    vecs[7]  = '{8'h00, 8'h20, 1'b1, 1'b1, 1'b0, 3'd5, 8'h20, 1'b1};
    vecs[8]  = '{8'h00, 8'h20, 1'b1, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0};
    vecs[9]  = '{8'h00, 8'h20, 1'b1, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0};
    vecs[10] = '{8'h40, 8'hBF, 1'b1, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0};
    vecs[11] = '{8'h40, 8'hBF, 1'b1, 1'b0, 1'b1, 3'd6, 8'h40, 1'b1};
    vecs[12] = '{8'h01, 8'hBF, 1'b1, 1'b0, 1'b0, 3'd6, 8'h40, 1'b1};
    vecs[13] = '{8'h41, 8'hBF, 1'b1, 1'b0, 1'b0, 3'd6, 8'h00, 1'b0};
    vecs[14] = '{8'h41, 8'hBF, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1};

    // Reset state
    do_reset();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_q_valid", 32'(q_valid), 0);
    check("rst_sel", 32'(sel), 0);

    // Single requester burst, withdrawal, and ptr wrap 7 -> 0
    for (int i = 0; i < 15; i++) begin
      req = vecs[i].req; din = vecs[i].din; q_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_q", i),       32'(q),       32'(vecs[i].e_q));
      check($sformatf("vec%0d_q_valid", i), 32'(q_valid), 32'(vecs[i].e_qv));
      check($sformatf("vec%0d_sel", i),     32'(sel),     32'(vecs[i].e_sel));
      check($sformatf("vec%0d_gnt", i),     32'(gnt),     32'(vecs[i].e_gnt));
      check($sformatf("vec%0d_busy", i),    32'(busy),    32'(vecs[i].e_busy));
      next_cyc();
    end

    // Backpressure: stalls do not count toward the burst
    do_reset();
    req = 8'h08; din = 8'h08; q_ready = 1'b0;
    #1;
    grant_run(3, 5);

    // Reset mid-burst, then a fresh full burst to the same requester
    do_reset();
    req = 8'h04; din = 8'h04; q_ready = 1'b1;
    next_cyc();
    #1;
    check("mid_busy", 32'(busy), 1);
    check("mid_sel", 32'(sel), 2);
    next_cyc();
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_q_valid", 32'(q_valid), 0);
    check("mid_rst_sel", 32'(sel), 0);
    grant_run(2, 0);

    // Round-robin across all 8 with 3 stall cycles in the third grant
    do_reset();
    req = 8'hFF; din = 8'hFF; q_ready = 1'b1;
    #1;
    for (int g = 0; g < 9; g++) begin
      grant_run(g % 8, (g == 2) ? 3 : 0);
`ifdef MUX_ARB_STATS_EN
      if (g == 7) begin
        check("grant_cnt", 32'(grant_cnt), 8);
        check("stall_cnt", 32'(stall_cnt), 3);
      end
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 bit multiplexer among 8 single-bit requesters.
- Picks one requester and drives the mux select.
- Holds the grant for a burst of up to BURST_LEN accepted beats, then rotates priority.
- Presents the selected bit downstream with a valid/ready handshake. It sits between the requester bank and the consumer of the muxed bit.

Parameters:
- BURST_LEN, 4, max beats per grant before forced release; legal 1..16.
- BEAT_W, 4, beat counter width (localparam, derived as clog2(16)); not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  8  per-requester request; bit i high means requester i has data.
- in  input  8  per-requester data bit; in[i] is meaningful while req[i] is high.
- q_ready  input  1  downstream accepts q this cycle.
- q  output  1  muxed data bit, equal to in[sel] (combinational through the 8:1 mux).
- q_valid  output  1  q holds a valid beat.
- sel  output  3  current mux select, equal to the granted index.
- gnt  output  8  one-hot grant; all zero when idle.
- busy  output  1  grant active.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, sel=0, gnt=0, busy=0, q_valid=0, ptr=0, beat_cnt=0. Reset overrides everything, including mid-burst; no beat is considered transferred in the reset cycle.
- State IDLE:
  - busy=0, gnt=0, q_valid=0.
  - If req is nonzero, select the first i with req[i]=1, scanning ptr, ptr+1, … , ptr+7 mod 8.
  - Register sel<=i, gnt<=1<<i, beat_cnt<=0, then go to GRANT.
  - Grant latency is 1 cycle from req seen in IDLE.
- State GRANT:
  - busy=1.
  - q_valid = req[sel]; q = in[sel].
  - Transfer occurs when q_valid & q_ready. Each transfer increments beat_cnt.
- Release from GRANT to IDLE occurs when either:
  - (a) a transfer happens with beat_cnt==BURST_LEN-1, or
  - (b) req[sel]==0 (requester withdrew; no transfer that cycle).
- On release:
  - ptr<=sel+1 (3-bit wrap, so 7 wraps to 0).
  - gnt<=0, busy<=0.
  - sel holds its last value.
  - There is one mandatory IDLE bubble cycle between grants.
- q_ready low: the grant is held indefinitely, q_valid stays high, and beat_cnt is unchanged. Stalls do not count toward the burst.
- Requests from non-granted indices are ignored until release. A requester that raises req while not granted waits its round-robin turn.
- BURST_LEN=1: release after every transfer. Rotation is strict, one beat per requester per two cycles.
- All req=0 in IDLE: stay in IDLE; outputs remain at reset values except sel, which holds.
- Fairness: with all 8 requesting continuously, each index is granted exactly once per 8 grants.

Optional Feature:
- Macro: MUX_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt, 16 bits, counting completed grants (releases of either kind). It wraps at 65535→0 and resets to 0.
  - Adds output stall_cnt, 16 bits, counting GRANT cycles with q_valid & !q_ready. It saturates at 65535 and resets to 0.
- Undefined: neither port nor the counters exist. Core behaviour is identical in both cases.

Decomposition:
- Shared package mux_arb_pkg holds:
  - enum arb_state_t {IDLE, GRANT};
  - localparam N_REQ=8, SEL_W=3;
  - function rr_pick(req, ptr), returning the index and a found flag.
- One sub-module: muxer8, the existing 8:1 mux, instantiated with in, sel and q. The arbiter never re-implements the mux.
- The rotating priority encoder stays inline via the package function.

Test Plan:
- Reset mid-burst: grant idx 2, after 2 transfers assert rst for 1 cycle → next cycle gnt=0, busy=0, q_valid=0, ptr=0; with req=8'h04 still high, a fresh grant occurs with beat_cnt=0.
- Single requester: req=8'h20, in[5]=1, q_ready=1, BURST_LEN=4 → gnt=8'h20 and sel=5 one cycle later; 4 consecutive q_valid beats with q=1; then 1 IDLE cycle; then re-grant to 5.
- Round-robin: req=8'hFF held, q_ready=1 → grant order 0,1,2,…,7,0, each grant 4 beats followed by 1 bubble.
- Backpressure: grant idx 3, q_ready=0 for 5 cycles → q_valid stays high and beat_cnt stays 0; then q_ready=1 → exactly 4 transfers, then release.
- Withdrawal: grant idx 6, after 1 transfer drop req[6] → release that cycle with no transfer; ptr=7; with req=8'h41 the next grant goes to 0 (scan 7,0).
- With MUX_ARB_STATS_EN, after the round-robin run of 8 grants with 3 stall cycles → grant_cnt=8, stall_cnt=3.
